tlb_mmu: RTL and testbench

//  Joint TLB that consumes CP0 Index/EntryHi/EntryLo0/EntryLo1 and executes TLBR/TLBWI/TLBWR/TLBP.

---
 rtl/tlb_mmu.sv | 205 ++++++++++++++++++++
 tb/tb_tlb_mmu.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_mmu.sv
// Joint TLB with CP0 maintenance ops (TLBR/TLBWI/TLBWR/TLBP) and a one-cycle registered translation.
// Optional macro TLB_UNMAPPED_SEG_EN: kseg0/kseg1 (vaddr[31:30]==2'b10) bypass the TLB.
module tlb_mmu #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] index_i,
  input  logic [31:0] entry_hi_i,
  input  logic [31:0] entry_lo_0_i,
  input  logic [31:0] entry_lo_1_i,
  input  logic [2:0]  op_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_vaddr_i,
  input  logic        req_store_i,
  output logic        cp0_we_o,
  output logic [31:0] cp0_index_o,
  output logic [31:0] cp0_entry_hi_o,
  output logic [31:0] cp0_entry_lo_0_o,
  output logic [31:0] cp0_entry_lo_1_o,
  output logic        cp0_index_we_o,
  output logic [31:0] random_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_paddr_o,
  output logic        exc_refill_o,
  output logic        exc_invalid_o,
  output logic        exc_modified_o
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_TLBR  = 3'd1,
    OP_TLBWI = 3'd2,
    OP_TLBWR = 3'd3,
    OP_TLBP  = 3'd4
  } tlb_op_e;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  tlb_entry_t       tlb [TLB_ENTRIES];
  logic [IDX_W-1:0] random;
  tlb_op_e          op;

  assign op       = tlb_op_e'(op_i);
  assign random_o = {{(32-IDX_W){1'b0}}, random};

  // Sink for CP0 bits the TLB never looks at.
  logic unused_bits;
  assign unused_bits = ^{index_i[31:IDX_W], entry_hi_i[12:8],
                         entry_lo_0_i[31:26], entry_lo_1_i[31:26]};

  // Combinational CAM searches; descending loop makes the lowest index win.
  logic             lk_hit, pr_hit;
  logic [IDX_W-1:0] lk_idx, pr_idx;

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    pr_hit = 1'b0;
    pr_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (tlb[i].vpn2 == req_vaddr_i[31:13] &&
          (tlb[i].g || tlb[i].asid == entry_hi_i[7:0])) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (tlb[i].vpn2 == entry_hi_i[31:13] &&
          (tlb[i].g || tlb[i].asid == entry_hi_i[7:0])) begin
        pr_hit = 1'b1;
        pr_idx = IDX_W'(i);
      end
    end
  end

  // Translation result for the request presented this cycle.
  tlb_entry_t  lk_e;
  logic [19:0] lk_pfn;
  logic        lk_v, lk_d, bypass;
  logic        nxt_refill, nxt_invalid, nxt_modified;
  logic [31:0] nxt_paddr;

`ifdef TLB_UNMAPPED_SEG_EN
  assign bypass = (req_vaddr_i[31:30] == 2'b10);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    lk_e         = tlb[lk_idx];
    lk_pfn       = req_vaddr_i[12] ? lk_e.pfn1 : lk_e.pfn0;
    lk_v         = req_vaddr_i[12] ? lk_e.v1   : lk_e.v0;
    lk_d         = req_vaddr_i[12] ? lk_e.d1   : lk_e.d0;
    nxt_refill   = 1'b0;
    nxt_invalid  = 1'b0;
    nxt_modified = 1'b0;
    nxt_paddr    = 32'h0;
    if (bypass) begin
      nxt_paddr = {3'b000, req_vaddr_i[28:0]};
    end else if (!lk_hit) begin
      nxt_refill = 1'b1;
    end else if (!lk_v) begin
      nxt_invalid = 1'b1;
    end else if (req_store_i && !lk_d) begin
      nxt_modified = 1'b1;
    end else begin
      nxt_paddr = {lk_pfn, req_vaddr_i[11:0]};
    end
  end

  // Entry image built from the CP0 registers for TLBWI/TLBWR.
  tlb_entry_t       wr_e;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;

  always_comb begin
    wr_e.vpn2 = entry_hi_i[31:13];
    wr_e.asid = entry_hi_i[7:0];
    wr_e.g    = entry_lo_0_i[0] & entry_lo_1_i[0];
    wr_e.pfn0 = entry_lo_0_i[25:6];
    wr_e.c0   = entry_lo_0_i[5:3];
    wr_e.d0   = entry_lo_0_i[2];
    wr_e.v0   = entry_lo_0_i[1];
    wr_e.pfn1 = entry_lo_1_i[25:6];
    wr_e.c1   = entry_lo_1_i[5:3];
    wr_e.d1   = entry_lo_1_i[2];
    wr_e.v1   = entry_lo_1_i[1];
    wr_en     = (op == OP_TLBWI) || (op == OP_TLBWR);
    wr_idx    = (op == OP_TLBWR) ? random : index_i[IDX_W-1:0];
  end

  // NOTE: the table is reset explicitly because software relies on every entry reading V=0;
  // this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) tlb[i] <= '0;
      random <= IDX_W'(TLB_ENTRIES - 1);
    end else begin
      // NOTE: non-blocking assignments here let same-cycle TLBR/TLBP/lookup see the old contents.
      if (wr_en) tlb[wr_idx] <= wr_e;
      random <= random - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_o   <= 1'b0;
      resp_paddr_o   <= 32'h0;
      exc_refill_o   <= 1'b0;
      exc_invalid_o  <= 1'b0;
      exc_modified_o <= 1'b0;
    end else begin
      resp_valid_o   <= req_valid_i;
      resp_paddr_o   <= req_valid_i ? nxt_paddr : 32'h0;
      exc_refill_o   <= req_valid_i & nxt_refill;
      exc_invalid_o  <= req_valid_i & nxt_invalid;
      exc_modified_o <= req_valid_i & nxt_modified;
    end
  end

  tlb_entry_t rd_e;
  assign rd_e = tlb[index_i[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cp0_we_o         <= 1'b0;
      cp0_index_we_o   <= 1'b0;
      cp0_index_o      <= 32'h0;
      cp0_entry_hi_o   <= 32'h0;
      cp0_entry_lo_0_o <= 32'h0;
      cp0_entry_lo_1_o <= 32'h0;
    end else begin
      cp0_we_o         <= 1'b0;
      cp0_index_we_o   <= 1'b0;
      cp0_index_o      <= 32'h0;
      cp0_entry_hi_o   <= 32'h0;
      cp0_entry_lo_0_o <= 32'h0;
      cp0_entry_lo_1_o <= 32'h0;
      if (op == OP_TLBR) begin
        cp0_we_o         <= 1'b1;
        cp0_entry_hi_o   <= {rd_e.vpn2, 5'b00000, rd_e.asid};
        cp0_entry_lo_0_o <= {6'b0, rd_e.pfn0, rd_e.c0, rd_e.d0, rd_e.v0, rd_e.g};
        cp0_entry_lo_1_o <= {6'b0, rd_e.pfn1, rd_e.c1, rd_e.d1, rd_e.v1, rd_e.g};
      end else if (op == OP_TLBP) begin
        cp0_we_o       <= 1'b1;
        cp0_index_we_o <= 1'b1;
        cp0_index_o    <= pr_hit ? 32'(pr_idx) : 32'h8000_0000;
      end
    end
  end

endmodule

// File: tb/tb_tlb_mmu.sv
// Directed self-checking bench for tlb_mmu: inputs change on negedge, outputs sampled on the next negedge.
module tb_tlb_mmu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] index_i, entry_hi_i, entry_lo_0_i, entry_lo_1_i;
  logic [2:0]  op_i;
  logic        req_valid_i, req_store_i;
  logic [31:0] req_vaddr_i;
  logic        cp0_we_o, cp0_index_we_o;
  logic [31:0] cp0_index_o, cp0_entry_hi_o, cp0_entry_lo_0_o, cp0_entry_lo_1_o;
  logic [31:0] random_o, resp_paddr_o;
  logic        resp_valid_o, exc_refill_o, exc_invalid_o, exc_modified_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] OP_NONE = 3'd0, OP_TLBR = 3'd1, OP_TLBWI = 3'd2,
                         OP_TLBWR = 3'd3, OP_TLBP = 3'd4;

  tlb_mmu dut (
    .clk(clk), .rst(rst),
    .index_i(index_i), .entry_hi_i(entry_hi_i),
    .entry_lo_0_i(entry_lo_0_i), .entry_lo_1_i(entry_lo_1_i),
    .op_i(op_i), .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i),
    .req_store_i(req_store_i),
    .cp0_we_o(cp0_we_o), .cp0_index_o(cp0_index_o),
    .cp0_entry_hi_o(cp0_entry_hi_o), .cp0_entry_lo_0_o(cp0_entry_lo_0_o),
    .cp0_entry_lo_1_o(cp0_entry_lo_1_o), .cp0_index_we_o(cp0_index_we_o),
    .random_o(random_o), .resp_valid_o(resp_valid_o), .resp_paddr_o(resp_paddr_o),
    .exc_refill_o(exc_refill_o), .exc_invalid_o(exc_invalid_o),
    .exc_modified_o(exc_modified_o)
  );

  always #5 clk = ~clk;

  // Response packed as {valid, refill, invalid, modified, paddr}.
  function automatic logic [35:0] resp_vec();
    return {resp_valid_o, exc_refill_o, exc_invalid_o, exc_modified_o, resp_paddr_o};
  endfunction

  function automatic logic [129:0] cp0_vec();
    return {cp0_we_o, cp0_index_we_o, cp0_index_o, cp0_entry_hi_o,
            cp0_entry_lo_0_o, cp0_entry_lo_1_o};
  endfunction

  task automatic set_cp0(input logic [31:0] idx, hi, lo0, lo1);
    index_i = idx; entry_hi_i = hi; entry_lo_0_i = lo0; entry_lo_1_i = lo1;
  endtask

  // One translation request; returns the response seen the next cycle.
  task automatic lookup(input logic [31:0] va, input logic st, output logic [35:0] got);
    req_valid_i = 1'b1; req_vaddr_i = va; req_store_i = st;
    @(negedge clk);
    got = resp_vec();
    req_valid_i = 1'b0; req_store_i = 1'b0; req_vaddr_i = 32'h0;
  endtask

  // Issue one single-cycle op and advance to the cycle where its result is visible.
  task automatic issue(input logic [2:0] op);
    op_i = op;
    @(negedge clk);
    op_i = OP_NONE;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_i = OP_NONE; req_valid_i = 1'b0; req_store_i = 1'b0;
    req_vaddr_i = 32'h0; set_cp0(0, 0, 0, 0);
    #2 do_reset();
    n_checks++;
    if ({resp_vec(), cp0_vec()} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%h expected all zero", resp_vec(), cp0_vec());
    end
    n_checks++;
    if (random_o !== 32'd15) begin
      n_fail++; $display("FAIL reset_random: got %0d expected 15", random_o);
    end
  endtask

  task automatic test_probe_empty();
    set_cp0(0, 32'h0000_2000, 0, 0);
    issue(OP_TLBP);
    n_checks++;
    if ({cp0_we_o, cp0_index_we_o, cp0_index_o} !== {2'b11, 32'h8000_0000}) begin
      n_fail++; $display("FAIL probe_miss: got we=%b iwe=%b idx=%h expected 1 1 80000000",
                         cp0_we_o, cp0_index_we_o, cp0_index_o);
    end
    @(negedge clk);
    n_checks++;
    if (cp0_vec() !== '0) begin
      n_fail++; $display("FAIL probe_pulse_width: got %h expected all zero", cp0_vec());
    end
  endtask

  task automatic test_translate();
    logic [35:0] got;
    set_cp0(3, 32'h0040_0005, 32'h0000_1046, 32'h0000_1086);
    issue(OP_TLBWI);
    lookup(32'h0040_0123, 1'b0, got);
    n_checks++;
    if (got !== {4'b1000, 32'h0004_1123}) begin
      n_fail++; $display("FAIL xlate_even: got %h expected %h", got, {4'b1000, 32'h0004_1123});
    end
    lookup(32'h0040_1ABC, 1'b1, got);
    n_checks++;
    if (got !== {4'b1000, 32'h0004_2ABC}) begin
      n_fail++; $display("FAIL xlate_odd_store: got %h expected %h", got, {4'b1000, 32'h0004_2ABC});
    end
    @(negedge clk);
    n_checks++;
    if (resp_vec() !== '0) begin
      n_fail++; $display("FAIL resp_idle: got %h expected 0", resp_vec());
    end
  endtask

  task automatic test_exceptions();
    logic [35:0] got;
    entry_hi_i = 32'h0040_0006;
    lookup(32'h0040_0123, 1'b0, got);
    n_checks++;
    if (got !== {4'b1100, 32'h0}) begin
      n_fail++; $display("FAIL exc_refill_asid: got %h expected %h", got, {4'b1100, 32'h0});
    end
    set_cp0(3, 32'h0040_0005, 32'h0000_1044, 32'h0000_1082);
    issue(OP_TLBWI);
    lookup(32'h0040_0123, 1'b0, got);
    n_checks++;
    if (got !== {4'b1010, 32'h0}) begin
      n_fail++; $display("FAIL exc_invalid: got %h expected %h", got, {4'b1010, 32'h0});
    end
    // Store to an invalid page must report invalid, not modified.
    lookup(32'h0040_0123, 1'b1, got);
    n_checks++;
    if (got !== {4'b1010, 32'h0}) begin
      n_fail++; $display("FAIL exc_prio_inv_mod: got %h expected %h", got, {4'b1010, 32'h0});
    end
    lookup(32'h0040_1ABC, 1'b1, got);
    n_checks++;
    if (got !== {4'b1001, 32'h0}) begin
      n_fail++; $display("FAIL exc_modified: got %h expected %h", got, {4'b1001, 32'h0});
    end
    lookup(32'h0040_1ABC, 1'b0, got);
    n_checks++;
    if (got !== {4'b1000, 32'h0004_2ABC}) begin
      n_fail++; $display("FAIL odd_load_clean_d: got %h expected %h", got, {4'b1000, 32'h0004_2ABC});
    end
  endtask

  task automatic test_write_bypass();
    logic [35:0] got;
    // Hi[12:8] set on purpose: they must read back as zero.
    set_cp0(3, 32'h0040_1F05, 32'h0000_2046, 32'h0000_1082);
    op_i = OP_TLBWI;
    lookup(32'h0040_0123, 1'b0, got);
    op_i = OP_NONE;
    n_checks++;
    if (got !== {4'b1010, 32'h0}) begin
      n_fail++; $display("FAIL same_cycle_old: got %h expected %h", got, {4'b1010, 32'h0});
    end
    lookup(32'h0040_0123, 1'b0, got);
    n_checks++;
    if (got !== {4'b1000, 32'h0008_1123}) begin
      n_fail++; $display("FAIL next_cycle_new: got %h expected %h", got, {4'b1000, 32'h0008_1123});
    end
  endtask

  task automatic test_back_to_back();
    set_cp0(3, 32'h0040_0005, 32'h0, 32'h0);
    op_i = OP_TLBR;
    @(negedge clk);
    op_i = OP_TLBP;
    n_checks++;
    if (cp0_vec() !== {2'b10, 32'h0, 32'h0040_0005, 32'h0000_2046, 32'h0000_1082}) begin
      n_fail++; $display("FAIL tlbr_readback: got %h expected %h", cp0_vec(),
                         {2'b10, 32'h0, 32'h0040_0005, 32'h0000_2046, 32'h0000_1082});
    end
    @(negedge clk);
    op_i = OP_NONE;
    n_checks++;
    if (cp0_vec() !== {2'b11, 32'd3, 96'h0}) begin
      n_fail++; $display("FAIL tlbp_hit: got %h expected %h", cp0_vec(), {2'b11, 32'd3, 96'h0});
    end
  endtask

  task automatic test_random_tlbwr();
    logic [35:0] got;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if (random_o !== 32'((15 - i) & 15)) begin
        n_fail++; $display("FAIL random_seq[%0d]: got %0d expected %0d", i, random_o, (15 - i) & 15);
      end
      @(negedge clk);
    end
    n_checks++;
    if (random_o !== 32'd7) begin
      n_fail++; $display("FAIL random_before_wr: got %0d expected 7", random_o);
    end
    set_cp0(0, 32'h0080_0007, 32'h0000_3046, 32'h0000_3086);
    op_i = OP_TLBWR;
    @(negedge clk);
    op_i = OP_TLBP;
    @(negedge clk);
    op_i = OP_NONE;
    n_checks++;
    if ({cp0_we_o, cp0_index_we_o, cp0_index_o} !== {2'b11, 32'd7}) begin
      n_fail++; $display("FAIL tlbwr_slot: got we=%b iwe=%b idx=%h expected 1 1 00000007",
                         cp0_we_o, cp0_index_we_o, cp0_index_o);
    end
    lookup(32'h0080_0123, 1'b0, got);
    n_checks++;
    if (got !== {4'b1000, 32'h000C_1123}) begin
      n_fail++; $display("FAIL tlbwr_xlate: got %h expected %h", got, {4'b1000, 32'h000C_1123});
    end
  endtask

  task automatic test_reset_mid_op();
    // Write and request pending when reset hits: nothing must survive.
    set_cp0(5, 32'h0100_0001, 32'h0000_4046, 32'h0000_4086);
    op_i = OP_TLBWI; req_valid_i = 1'b1; req_vaddr_i = 32'h0040_0123;
    #2 rst = 1'b0;
    @(negedge clk);
    op_i = OP_NONE; req_valid_i = 1'b0;
    n_checks++;
    if ({resp_vec(), cp0_vec()} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h/%h expected all zero", resp_vec(), cp0_vec());
    end
    rst = 1'b1;
    issue(OP_TLBP);
    n_checks++;
    if (cp0_index_o !== 32'h8000_0000) begin
      n_fail++; $display("FAIL reset_mid_no_write: got %h expected 80000000", cp0_index_o);
    end
  endtask

  task automatic test_unmapped();
    logic [35:0] got;
    entry_hi_i = 32'h0;
    lookup(32'hA000_1234, 1'b1, got);
    n_checks++;
`ifdef TLB_UNMAPPED_SEG_EN
    if (got !== {4'b1000, 32'h0000_1234}) begin
      n_fail++; $display("FAIL unmapped_kseg1: got %h expected %h", got, {4'b1000, 32'h0000_1234});
    end
`else
    if (got !== {4'b1100, 32'h0}) begin
      n_fail++; $display("FAIL kseg1_refill: got %h expected %h", got, {4'b1100, 32'h0});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_probe_empty();
    test_translate();
    test_exceptions();
    test_write_bypass();
    test_back_to_back();
    test_random_tlbwr();
    test_reset_mid_op();
    test_unmapped();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
